// File: rtl/ssp_master_pkg.sv
// Shared types and frame helpers for the SSP master: FSM states, field widths
// and the 16-bit frame packer.
package ssp_master_pkg;
  localparam int FRAME_LEN = 16;
  localparam int RA_W      = 3;
  localparam int DATA_W    = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Reads carry no payload, so the data field goes out as zeros.
  function automatic logic [FRAME_LEN-1:0] pack_frame(input logic [RA_W-1:0]   ra,
                                                      input logic              wnr,
                                                      input logic [DATA_W-1:0] wdata);
    return {ra, wnr, (wnr ? wdata : {DATA_W{1'b0}})};
  endfunction
endpackage

// File: rtl/ssp_clk_div.sv
// Half-period tick generator: while enabled, pulses tick_o every CLK_DIV cycles,
// counting from the cycle enable rises.
module ssp_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic en_i,
  output logic tick_o
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || tick_o) cnt_d = 8'd0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ssp_master.sv
// SSP master: serialises one 16-bit {RA, WnR, D} frame per accepted command and
// returns the last 12 MISO samples with a one-cycle rsp_valid pulse.
module ssp_master
  import ssp_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RA_W-1:0]   cmd_ra,
  input  logic              cmd_wnr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              SSP_SSEL,
  output logic              SSP_SCK,
  output logic              SSP_MOSI,
  input  logic              SSP_MISO,
  output state_e            dbg_state
);
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and never while Rst is high.
  state_e                 state_q;
  logic [FRAME_LEN-2:0]   tx_q;
  logic [DATA_W-1:0]      rx_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [4:0]             bit_q;
  logic                   fin_q;
  logic                   sck_q;
  logic                   mosi_q;
  logic                   ssel_q;
  logic                   rsp_valid_q;
  logic                   tick;
  logic [FRAME_LEN-1:0]   frame_w;

  assign frame_w = pack_frame(cmd_ra, cmd_wnr, cmd_wdata);

  ssp_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .Clk    (Clk),
    .Rst    (Rst),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      bit_q       <= 5'd0;
      fin_q       <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ssel_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= SETUP;
            mosi_q  <= frame_w[FRAME_LEN-1];
            tx_q    <= frame_w[FRAME_LEN-2:0];
            ssel_q  <= 1'b1;
            bit_q   <= 5'd0;
            fin_q   <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT;
            sck_q   <= 1'b1;
            rx_q    <= {rx_q[DATA_W-2:0], SSP_MISO};
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sck_q) begin
              sck_q <= 1'b0;
              if (bit_q == 5'd15) begin
                fin_q  <= 1'b1;
                mosi_q <= 1'b0;
              end else begin
                bit_q  <= bit_q + 5'd1;
                mosi_q <= tx_q[FRAME_LEN-2];
                tx_q   <= {tx_q[FRAME_LEN-3:0], 1'b0};
              end
            end else if (fin_q) begin
              // Low half of the 16th period has elapsed.
              state_q <= HOLD;
            end else begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[DATA_W-2:0], SSP_MISO};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q     <= GAP;
            ssel_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rx_q;
          end
        end
        GAP: begin
          if (tick) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE) && !Rst;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign SSP_SSEL  = ssel_q;
  assign SSP_SCK   = sck_q;
  assign SSP_MOSI  = mosi_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ssp_master.sv
// Self-checking bench for ssp_master: a CLK_DIV=4 instance with slave model and
// scoreboard, plus a CLK_DIV=2 instance for the fast-divider frame.
module tb_ssp_master;
  import ssp_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // CLK_DIV=4 instance
  logic v4 = 1'b0, wnr4 = 1'b0, miso4 = 1'b0;
  logic [2:0]  ra4 = '0;
  logic [11:0] wd4 = '0;
  logic rdy4, rv4, busy4, ssel4, sck4, mosi4;
  logic [11:0] rd4;
  state_e st4;

  // CLK_DIV=2 instance
  logic v2 = 1'b0, wnr2 = 1'b0, miso2 = 1'b0;
  logic [2:0]  ra2 = '0;
  logic [11:0] wd2 = '0;
  logic rdy2, rv2, busy2, ssel2, sck2, mosi2;
  logic [11:0] rd2;
  state_e st2;

  ssp_master #(.CLK_DIV(4)) dut4 (
    .Clk(clk), .Rst(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_ra(ra4),
    .cmd_wnr(wnr4), .cmd_wdata(wd4), .rsp_valid(rv4), .rsp_rdata(rd4),
    .busy(busy4), .SSP_SSEL(ssel4), .SSP_SCK(sck4), .SSP_MOSI(mosi4),
    .SSP_MISO(miso4), .dbg_state(st4)
  );

  ssp_master #(.CLK_DIV(2)) dut2 (
    .Clk(clk), .Rst(rst), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_ra(ra2),
    .cmd_wnr(wnr2), .cmd_wdata(wd2), .rsp_valid(rv2), .rsp_rdata(rd2),
    .busy(busy2), .SSP_SSEL(ssel2), .SSP_SCK(sck2), .SSP_MOSI(mosi2),
    .SSP_MISO(miso2), .dbg_state(st2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries: {expected MOSI word, expected rsp_rdata}
  logic [27:0] exp_q[$];
  logic [27:0] exp_e;

  // Monitor and slave model for dut4, evaluated on the falling edge
  logic [15:0] slv4 = '0;
  logic [15:0] cap4 = '0;
  logic prev_sck4 = 1'b0, prev_ssel4 = 1'b0, hold4 = 1'b0, stab4 = 1'b0;
  logic end_mosi4 = 1'b1, rv_pend4 = 1'b0;
  int rises4 = 0, idx4 = 0, acc4 = 0, rsp4 = 0, t0_4 = 0, t0_prev4 = 0;
  int low4 = 0, gap4 = 0, lat4 = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_sck4 = 1'b0;
      prev_ssel4 = 1'b0;
      rv_pend4 = 1'b0;
      low4 = 0;
    end else begin
      if (rv_pend4) begin
        checks++;
        if (rv4 !== 1'b0) begin
          errors++;
          $display("FAIL rsp_pulse_width: rsp_valid=%b one cycle later, want 0", rv4);
        end
        rv_pend4 = 1'b0;
      end
      if (ssel4 && !prev_ssel4) begin
        cap4 = '0; rises4 = 0; stab4 = 1'b0; idx4 = 0; end_mosi4 = 1'b1;
        miso4 = slv4[15];
        gap4 = low4;
      end
      if (!ssel4) low4++;
      else low4 = 0;
      if (sck4 && !prev_sck4) begin
        cap4 = {cap4[14:0], mosi4};
        rises4++;
        hold4 = mosi4;
      end else if (sck4 && (mosi4 !== hold4)) begin
        stab4 = 1'b1;
      end
      if (!sck4 && prev_sck4) begin
        idx4++;
        if (idx4 < 16) miso4 = slv4[15-idx4];
        else end_mosi4 = mosi4;
      end
      if (v4 && rdy4) begin
        acc4++;
        t0_prev4 = t0_4;
        t0_4 = cyc + 1;
      end
      if (rv4) begin
        rsp4++;
        rv_pend4 = 1'b1;
        lat4 = cyc + 1 - t0_4;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with nothing pending", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          checks++;
          if (cap4 !== exp_e[27:12]) begin
            errors++;
            $display("FAIL mosi_word: got %h want %h", cap4, exp_e[27:12]);
          end
          checks++;
          if (rd4 !== exp_e[11:0]) begin
            errors++;
            $display("FAIL rsp_rdata: got %h want %h", rd4, exp_e[11:0]);
          end
          checks++;
          if (lat4 != 137) begin
            errors++;
            $display("FAIL rsp_latency: got T0+%0d want T0+137", lat4);
          end
          checks++;
          if (rises4 != 16) begin
            errors++;
            $display("FAIL sck_rises: got %0d want 16", rises4);
          end
          checks++;
          if (stab4 || (end_mosi4 !== 1'b0)) begin
            errors++;
            $display("FAIL mosi_stable_end: unstable=%b mosi_after_last_fall=%b want 0/0", stab4, end_mosi4);
          end
          checks++;
          if (ssel4 !== 1'b0) begin
            errors++;
            $display("FAIL ssel_at_rsp: got %b want 0", ssel4);
          end
        end
      end
      prev_sck4 = sck4;
      prev_ssel4 = ssel4;
    end
  end

  // Monitor for dut2
  logic prev_sck2 = 1'b0, hold2 = 1'b0, stab2 = 1'b0;
  int rises2 = 0, rsp2 = 0, t0_2 = 0, lat2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_sck2 = 1'b0;
    end else begin
      if (sck2 && !prev_sck2) begin
        rises2++;
        hold2 = mosi2;
      end else if (sck2 && (mosi2 !== hold2)) begin
        stab2 = 1'b1;
      end
      if (v2 && rdy2) t0_2 = cyc + 1;
      if (rv2) begin
        rsp2++;
        lat2 = cyc + 1 - t0_2;
      end
      prev_sck2 = sck2;
    end
  end

  task automatic send4(input logic [2:0] ra, input logic wnr, input logic [11:0] wd,
                       input logic [15:0] slv, input logic [15:0] exp_word, input bit push);
    bit ok;
    ok = 1'b0;
    slv4 = slv;
    if (push) exp_q.push_back({exp_word, slv[11:0]});
    @(posedge clk); #1;
    v4 = 1'b1; ra4 = ra; wnr4 = wnr; wd4 = wd;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rdy4) ok = 1'b1;
    end
    @(posedge clk); #1;
    v4 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b, want 1 within 400 cycles", rdy4);
    end
  endtask

  task automatic wait_rsp4(input int target);
    for (int i = 0; i < 600 && rsp4 < target; i++) @(negedge clk);
    checks++;
    if (rsp4 < target) begin
      errors++;
      $display("FAIL rsp_timeout: responses=%0d want %0d", rsp4, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ssel4, sck4, mosi4, busy4, rv4, rdy4} !== 6'b0 || rd4 !== 12'h000 || st4 !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: ssel/sck/mosi/busy/rv/rdy=%b rdata=%h state=%0d want 000000/000/0",
               {ssel4, sck4, mosi4, busy4, rv4, rdy4}, rd4, st4);
    end
    @(posedge clk); #1;
    rst = 1'b0; v4 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy4 !== 1'b1 || busy4 !== 1'b0 || ssel4 !== 1'b0 || acc4 != 0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b ssel=%b accepts=%0d want 1/0/0/0", rdy4, busy4, ssel4, acc4);
    end
  endtask

  task automatic test_write();
    int r0;
    r0 = rsp4;
    send4(3'b101, 1'b1, 12'hA5C, 16'h1234, 16'hBA5C, 1'b1);
    @(negedge clk);
    checks++;
    if ({busy4, ssel4, sck4, mosi4} !== 4'b1101 || st4 !== SETUP) begin
      errors++;
      $display("FAIL setup_phase: busy/ssel/sck/mosi=%b state=%0d want 1101/SETUP", {busy4, ssel4, sck4, mosi4}, st4);
    end
    wait_rsp4(r0 + 1);
  endtask

  task automatic test_read();
    int r0;
    r0 = rsp4;
    send4(3'b010, 1'b0, 12'hFFF, 16'hF3C7, 16'h4000, 1'b1);
    wait_rsp4(r0 + 1);
    repeat (20) @(negedge clk);
    checks++;
    if (rd4 !== 12'h3C7) begin
      errors++;
      $display("FAIL rdata_hold: got %h want 3c7", rd4);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    bit ok1, ok2;
    r0 = rsp4; ok1 = 1'b0; ok2 = 1'b0;
    slv4 = 16'h0ABC;
    exp_q.push_back({16'h3123, 12'hABC});
    exp_q.push_back({16'hD456, 12'hABC});
    @(posedge clk); #1;
    v4 = 1'b1; ra4 = 3'b001; wnr4 = 1'b1; wd4 = 12'h123;
    for (int i = 0; i < 400 && !ok1; i++) begin
      @(negedge clk);
      if (rdy4) ok1 = 1'b1;
    end
    @(posedge clk); #1;
    ra4 = 3'b110; wd4 = 12'h456;
    for (int i = 0; i < 400 && !ok2; i++) begin
      @(negedge clk);
      if (rdy4) ok2 = 1'b1;
    end
    @(posedge clk); #1;
    v4 = 1'b0;
    wait_rsp4(r0 + 2);
    checks++;
    if (!ok1 || !ok2 || (t0_4 - t0_prev4) != 141) begin
      errors++;
      $display("FAIL b2b_accept_spacing: accepted=%b%b spacing=%0d want 11/141", ok1, ok2, t0_4 - t0_prev4);
    end
    checks++;
    if (gap4 < 4) begin
      errors++;
      $display("FAIL b2b_ssel_gap: low for %0d cycles want >=4", gap4);
    end
  endtask

  task automatic test_stall();
    int r0, a0;
    r0 = rsp4; a0 = acc4;
    send4(3'b011, 1'b1, 12'h0F0, 16'h0555, 16'h70F0, 1'b1);
    ra4 = 3'b111; wnr4 = 1'b0; wd4 = 12'hFFF;
    repeat ($urandom_range(5, 40)) @(posedge clk);
    #1 v4 = 1'b1;
    repeat ($urandom_range(3, 20)) @(posedge clk);
    #1 v4 = 1'b0;
    wait_rsp4(r0 + 1);
    checks++;
    if (acc4 - a0 != 1) begin
      errors++;
      $display("FAIL stall_accepts: got %0d accepts want 1", acc4 - a0);
    end
  endtask

  task automatic test_mid_reset();
    int r0;
    bit hit;
    hit = 1'b0;
    send4(3'b100, 1'b1, 12'h00F, 16'h0FFF, 16'h900F, 1'b0);
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (rises4 == 8) hit = 1'b1;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!hit || ssel4 !== 1'b0 || sck4 !== 1'b0 || busy4 !== 1'b0 || st4 !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: reached_bit7=%b ssel=%b sck=%b busy=%b state=%0d want 1/0/0/0/IDLE",
               hit, ssel4, sck4, busy4, st4);
    end
    r0 = rsp4;
    repeat (200) @(negedge clk);
    checks++;
    if (rsp4 != r0) begin
      errors++;
      $display("FAIL mid_reset_no_rsp: got %0d responses want 0", rsp4 - r0);
    end
    send4(3'b001, 1'b0, 12'h000, 16'h0C3A, 16'h2000, 1'b1);
    wait_rsp4(r0 + 1);
  endtask

  task automatic test_div2();
    bit ok;
    ok = 1'b0; rises2 = 0; stab2 = 1'b0;
    @(posedge clk); #1;
    v2 = 1'b1; ra2 = 3'b111; wnr2 = 1'b1; wd2 = 12'h5A5;
    @(posedge clk); #1;
    v2 = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rsp2 > 0) ok = 1'b1;
    end
    checks++;
    if (!ok || lat2 != 69) begin
      errors++;
      $display("FAIL div2_latency: done=%b got T0+%0d want T0+69", ok, lat2);
    end
    checks++;
    if (rises2 != 16 || stab2) begin
      errors++;
      $display("FAIL div2_sck: rises=%0d unstable=%b want 16/0", rises2, stab2);
    end
    checks++;
    if (rd2 !== 12'h000) begin
      errors++;
      $display("FAIL div2_rdata: got %h want 000", rd2);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_div2();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssp_master.md
SSP_MASTER -- requirements
Module: ssp_master

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is Clk, and the reset is Rst, synchronous and active-high.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning Clk cycles per SCK half-period; legal range is 2..255.
REQ-003 Port Clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-004 Port Rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port cmd_valid, input, 1 bit: host command request.
REQ-006 Port cmd_ready, output, 1 bit: block can accept a command.
REQ-007 Port cmd_ra, input, 3 bits: target SSP register address.
REQ-008 Port cmd_wnr, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port cmd_wdata, input, 12 bits: write data; don't-care for reads.
REQ-010 Port rsp_valid, output, 1 bit: one-cycle pulse marking frame completion.
REQ-011 Port rsp_rdata, output, 12 bits: data returned by the slave.
REQ-012 Port busy, output, 1 bit: a frame is in progress.
REQ-013 Port SSP_SSEL, output, 1 bit: slave select, active-high.
REQ-014 Port SSP_SCK, output, 1 bit: serial clock, idle low.
REQ-015 Port SSP_MOSI, output, 1 bit: serial data to the slave (SSP_DI side).
REQ-016 Port SSP_MISO, input, 1 bit: serial data from the slave (SSP_DO side).

Function
REQ-017 A frame SHALL be 16 bits, sent MSB first: {RA[2:0], WnR, D[11:0]}.
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; this edge is T0.
- All cmd_* fields are captured at T0.
- Later changes to cmd_* SHALL be ignored.
REQ-019 cmd_ready SHALL be high only in state IDLE; cmd_valid while not ready has no effect.
REQ-020 The state machine SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
- IDLE -> SETUP on accept.
- SETUP -> SHIFT after CLK_DIV cycles.
- SHIFT -> HOLD after 16 SCK periods.
- HOLD -> GAP after CLK_DIV cycles.
- GAP -> IDLE after CLK_DIV cycles.
REQ-021 SSP_SSEL SHALL be high from T0+1 through T0+34*CLK_DIV; busy SHALL equal the state not being IDLE.
REQ-022 During SETUP, SSP_MOSI SHALL present frame bit 15 and SSP_SCK SHALL be low.
REQ-023 In SHIFT, each SCK period SHALL be CLK_DIV cycles high followed by CLK_DIV cycles low, 16 periods in total.
REQ-024 SSP_MISO SHALL be sampled in the Clk cycle in which SCK goes high.
REQ-025 SSP_MOSI SHALL advance to the next bit in the cycle SCK goes low; it SHALL hold its value while SCK is high.
REQ-026 After the 16th falling edge, SSP_MOSI SHALL be 0.
REQ-027 rsp_valid SHALL pulse for exactly one cycle at T0+34*CLK_DIV+1, coinciding with SSEL going low.
- It pulses for both reads and writes.
- rsp_rdata = the last 12 MISO samples, MSB first, held until the next rsp_valid.
REQ-028 GAP SHALL keep SSEL low for at least CLK_DIV cycles; the earliest next accept is T0+35*CLK_DIV+1.
REQ-029 The half-period counter SHALL be 8 bits; the bit counter SHALL be 5 bits and count 0..15 with no wrap into a 17th bit.
REQ-030 A frame, once started, SHALL complete; there is no abort input.

Reset
REQ-031 On the cycle after Rst is sampled high, outputs SHALL be:
- SSP_SSEL=0, SSP_SCK=0, SSP_MOSI=0;
- busy=0, rsp_valid=0, rsp_rdata=0;
- cmd_ready=0 while Rst is high, then 1.
REQ-032 Reset mid-frame SHALL abandon the frame:
- no rsp_valid for it;
- state=IDLE and all counters 0.
REQ-033 cmd_valid asserted during Rst SHALL NOT be accepted.

Structure
REQ-034 Package ssp_master_pkg SHALL hold:
- the state enum;
- FRAME_LEN=16, RA_W=3, DATA_W=12;
- a frame-pack function.
REQ-035 Sub-module ssp_clk_div SHALL generate the half-period tick from CLK_DIV; shift and FSM logic stay in ssp_master.

Verification
REQ-036 Write test: CLK_DIV=4, RA=3'b101, WnR=1, D=12'hA5C -> MOSI captured at SCK rises = 16'hBA5C; rsp_valid at T0+137.
REQ-037 Read test: RA=3'b010, WnR=0; the slave model drives 12'h3C7 on the data bits -> MOSI word 16'h4000, rsp_rdata=12'h3C7.
REQ-038 Back-to-back test: cmd_valid held high for 2 commands -> SSEL low for at least CLK_DIV cycles between frames, and the second accept at T0+35*CLK_DIV+1.
REQ-039 Mid-frame reset test: Rst pulsed during bit 7 -> next cycle SSEL=0, SCK=0, and no rsp_valid; a new command afterwards completes normally.
REQ-040 CLK_DIV=2 test: exactly 16 SCK rising edges per frame, rsp_valid at T0+69, and MOSI stable during every SCK-high interval.
REQ-041 Stall test: cmd_valid pulsed while busy -> not accepted, and cmd_* changes after T0 do not alter the frame.
